dma_ctrl_param: RTL

- Parametrised successor to the team's 4-channel K580VT57-style DMA controller.
- Generalises channel count and address width, and adds rotating priority, TC-stop, a TC output, byte-pointer register readback and status-read clear.
- Sits between the CPU register bus and the system bus, arbitrating with the CPU via hrq/hlda.
- The CRT/FDC/tape drq sources feed drq[].

---
 rtl/dma_ctrl_param.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dma_ctrl_param.sv
// dma_ctrl_param: parametrised 8257-style DMA controller.
// CPU register file, fixed/rotating arbiter, T1..T3 cycle FSM.
//
// Ports:
//   clk, reset      clock; async active-high reset
//   ce              FSM clock enable
//   iaddr/idata     CPU register select / write data
//   odata           CPU read data
//   iwe_n/ird_n     CPU strobes, act after rising edge
//   drq/hlda        channel requests / bus grant
//   hrq/dack/tc     bus request / acknowledge / terminal count
//   oaddr           transfer address
//   owe_n/ord_n     memory write/read strobes
//   oiowe_n/oiord_n IO write/read strobes
module dma_ctrl_param #(
  parameter int CHANNELS = 4,
  parameter int AW = 16,
  parameter int IAW = $clog2(CHANNELS) + 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [IAW-1:0]      iaddr,
  input  logic [7:0]          idata,
  output logic [7:0]          odata,
  input  logic                iwe_n,
  input  logic                ird_n,
  input  logic [CHANNELS-1:0] drq,
  input  logic                hlda,
  output logic                hrq,
  output logic [CHANNELS-1:0] dack,
  output logic                tc,
  output logic [AW-1:0]       oaddr,
  output logic                owe_n,
  output logic                ord_n,
  output logic                oiowe_n,
  output logic                oiord_n
);

  localparam int CW = IAW - 2;
  localparam int NB = AW / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_T1, S_T2, S_T3
  } state_t;

  state_t state, nxt;

  logic [AW-1:0] addr_r [CHANNELS];
  logic [15:0]   cnt_r  [CHANNELS];
  logic [AW-1:0] a_wd   [CHANNELS];
  logic [15:0]   c_wd   [CHANNELS];
  logic [CHANNELS-1:0] a_we, c_we;

  logic [7:0]          mode;
  logic [CHANNELS-1:0] tc_flags;
  logic                upd;
  logic [1:0]          ptr, ptr_nx;
  logic [CW-1:0]       chn, last, start, win;
  logic [CHANNELS-1:0] mdrq;
  logic                found;

  logic           we_q1, we_q2, rd_q1, rd_q2;
  logic           wr_fire, rd_fire;
  logic [IAW-1:0] iaddr_q;
  logic [7:0]     idata_q;
  logic [CW-1:0]  wch;

  logic          t2, tc_hit, reload;
  logic          rd_t, wr_t;
  logic [1:0]    typ;
  logic [3:0]    tcp;
  logic [AW-1:0] ash;

  function automatic logic [CW-1:0] wrap(
    input logic [CW-1:0] s,
    input int            k
  );
    int t;
    t = int'(s) - k;
    if (t < 0) t = t + CHANNELS;
    return CW'(t);
  endfunction

  // Strobes are sampled twice so an action fires on the
  // cycle after the CPU releases the strobe.
  assign wr_fire = we_q1 & ~we_q2;
  assign rd_fire = rd_q1 & ~rd_q2;
  assign wch     = iaddr_q[IAW-2:1];

  assign mdrq   = drq & mode[CHANNELS-1:0];
  assign t2     = ce && (state == S_T2);
  assign tc_hit = (cnt_r[chn][13:0] == 14'd0);
  assign reload = mode[7] && (chn == CW'(CHANNELS - 2));
  assign typ    = cnt_r[chn][15:14];
  assign rd_t   = (typ == 2'b10);
  assign wr_t   = (typ == 2'b01);
  assign oaddr  = addr_r[chn];

  // Search descends from start; rotating mode starts
  // just below the last channel served.
  always_comb begin
    start = CW'(CHANNELS - 1);
    if (mode[4] && last != '0) start = last - 1'b1;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found && mdrq[wrap(start, k)]) begin
        found = 1'b1;
        win   = wrap(start, k);
      end
    end
  end

  always_comb begin
    if (iaddr_q[0])
      ptr_nx = (ptr == 2'd0) ? 2'd1 : 2'd0;
    else
      ptr_nx = (ptr == 2'(NB - 1)) ? 2'd0 : ptr + 2'd1;
  end

  always_comb begin
    odata = '0;
    ash   = '0;
    tcp   = '0;
    tcp[CHANNELS-1:0] = tc_flags;
    if (iaddr[IAW-1]) begin
      odata = {3'b000, upd, tcp};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i == int'(iaddr[IAW-2:1])) begin
          if (iaddr[0]) begin
            odata = (ptr == 2'd0) ? cnt_r[i][7:0]
                                  : cnt_r[i][15:8];
          end else begin
            ash   = addr_r[i] >> {ptr, 3'b000};
            odata = ash[7:0];
          end
        end
      end
    end
  end

  // Channel register write enables. The T2 update is
  // applied last so it overrides a colliding CPU write.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      a_we[i] = 1'b0;
      c_we[i] = 1'b0;
      a_wd[i] = addr_r[i];
      c_wd[i] = cnt_r[i];
    end
    if (wr_fire && !iaddr_q[IAW-1]) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i == int'(wch) ||
            (mode[7] && int'(wch) == CHANNELS - 2 &&
             i == CHANNELS - 1)) begin
          if (iaddr_q[0]) begin
            c_we[i] = 1'b1;
            if (ptr == 2'd0) c_wd[i][7:0]  = idata_q;
            else             c_wd[i][15:8] = idata_q;
          end else begin
            a_we[i] = 1'b1;
            for (int b = 0; b < NB; b++)
              if (ptr == 2'(b)) a_wd[i][b*8 +: 8] = idata_q;
          end
        end
      end
    end
    if (t2) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i == int'(chn)) begin
          if (!tc_hit) begin
            a_we[i] = 1'b1;
            c_we[i] = 1'b1;
            a_wd[i] = addr_r[i] + 1'b1;
            c_wd[i] = {cnt_r[i][15:14],
                       cnt_r[i][13:0] - 14'd1};
          end else if (reload) begin
            a_we[i] = 1'b1;
            c_we[i] = 1'b1;
            a_wd[i] = addr_r[CHANNELS-1];
            c_wd[i] = {cnt_r[i][15:14],
                       cnt_r[CHANNELS-1][13:0]};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (a_we[i]) addr_r[i] <= a_wd[i];
      if (c_we[i]) cnt_r[i]  <= c_wd[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q1    <= 1'b1;
      we_q2    <= 1'b1;
      rd_q1    <= 1'b1;
      rd_q2    <= 1'b1;
      iaddr_q  <= '0;
      idata_q  <= '0;
      mode     <= '0;
      tc_flags <= '0;
      upd      <= 1'b0;
      ptr      <= '0;
      chn      <= '0;
      last     <= '0;
    end else begin
      we_q1   <= iwe_n;
      we_q2   <= we_q1;
      rd_q1   <= ird_n;
      rd_q2   <= rd_q1;
      iaddr_q <= iaddr;
      idata_q <= idata;
      if (wr_fire) begin
        if (iaddr_q[IAW-1]) begin
          mode <= idata_q;
          ptr  <= '0;
        end else begin
          ptr <= ptr_nx;
        end
      end else if (rd_fire) begin
        if (iaddr_q[IAW-1]) begin
          tc_flags <= '0;
          upd      <= 1'b0;
        end else begin
          ptr <= ptr_nx;
        end
      end
      if (ce && state == S_WAIT) chn <= win;
      if (t2) begin
        if (mode[4]) last <= chn;
        if (tc_hit) begin
          tc_flags[chn] <= 1'b1;
          if (reload)       upd       <= 1'b1;
          else if (mode[5]) mode[chn] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   state <= S_IDLE;
    else if (ce) state <= nxt;
  end

  always_comb begin
    nxt     = state;
    hrq     = 1'b0;
    dack    = '0;
    tc      = 1'b0;
    ord_n   = 1'b1;
    owe_n   = 1'b1;
    oiord_n = 1'b1;
    oiowe_n = 1'b1;
    unique case (state)
      S_IDLE: if (|mdrq) nxt = S_WAIT;
      S_WAIT: begin
        hrq = 1'b1;
        if (~|mdrq)    nxt = S_IDLE;
        else if (hlda) nxt = S_T1;
      end
      S_T1: begin
        hrq = 1'b1;
        nxt = S_T2;
      end
      S_T2: begin
        hrq  = 1'b1;
        nxt  = S_T3;
        dack = CHANNELS'(1) << chn;
        tc   = tc_hit;
      end
      S_T3: begin
        hrq = 1'b1;
        nxt = (|mdrq) ? S_WAIT : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (state == S_T1 || state == S_T2) begin
      unique case (1'b1)
        rd_t:    ord_n   = 1'b0;
        wr_t:    oiord_n = 1'b0;
        default: ;
      endcase
    end
    if (state == S_T2) begin
      unique case (1'b1)
        rd_t:    oiowe_n = 1'b0;
        wr_t:    owe_n   = 1'b0;
        default: ;
      endcase
    end
  end

endmodule
